// File: rtl/doodle_sprite_fetch.sv
// Per-pixel Doodle sprite fetch: box test and RAM address, 3-stage pipeline,
// frame-counted crouch timer, and colour-key transparency.
module doodle_sprite_fetch #(
    parameter int unsigned SPRITE_W      = 32,
    parameter int unsigned CROUCH_FRAMES = 8,
    parameter logic [23:0] KEY_RGB       = 24'hFFFFFF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic [9:0]  DoodleX,
    input  logic [9:0]  DoodleY,
    input  logic        facing_right,
    input  logic        bounce,
    output logic [10:0] read_address,
    input  logic [23:0] data_nL,
    input  logic [23:0] data_nR,
    input  logic [23:0] data_cL,
    input  logic [23:0] data_cR,
    output logic [23:0] pixel_rgb,
    output logic        doodle_on
);

    localparam int unsigned CNT_W = $clog2(CROUCH_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CROUCH_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {StNormal, StCrouch} crouch_state_e;

    logic [10:0]   w_dx;
    logic [10:0]   w_dy;
    logic          w_in_box;
    logic [10:0]   w_addr;

    logic [10:0]   r_read_address;
    logic          r_inb1;
    logic          r_inb2;
    logic [23:0]   r_pixel_rgb;
    logic          r_doodle_on;

    crouch_state_e r_state;
    crouch_state_e w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic          r_fresh;
    logic          w_fresh_next;
    logic          r_disp_crouch;
    logic          r_disp_right;

    logic [23:0]   w_pix;
    logic          w_on_next;

    // 11-bit signed offsets so a wrapped 10-bit difference cannot alias into the box
    assign w_dx     = {1'b0, DrawX} - {1'b0, DoodleX};
    assign w_dy     = {1'b0, DrawY} - {1'b0, DoodleY};
    assign w_in_box = !w_dx[10] && (w_dx < 11'(SPRITE_W)) &&
                      !w_dy[10] && (w_dy < 11'(SPRITE_W));
    assign w_addr   = {1'b0, w_dy[4:0], w_dx[4:0]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_read_address <= '0;
            r_inb1         <= 1'b0;
            r_inb2         <= 1'b0;
        end else begin
            r_read_address <= w_in_box ? w_addr : 11'd0;
            r_inb1         <= w_in_box;
            r_inb2         <= r_inb1;
        end
    end

    // r_fresh marks a mid-frame bounce: the next frame_start starts the first
    // crouch frame rather than ending one, so it must not decrement.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fresh_next = r_fresh;
        if (bounce) begin
            w_state_next = StCrouch;
            w_cnt_next   = CNT_INIT;
            w_fresh_next = !frame_start;
        end else if (frame_start) begin
            w_fresh_next = 1'b0;
            if (r_state == StCrouch && !r_fresh) begin
                if (r_cnt == CNT_ONE) begin
                    w_state_next = StNormal;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= StNormal;
            r_cnt         <= '0;
            r_fresh       <= 1'b0;
            r_disp_crouch <= 1'b0;
            r_disp_right  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_fresh <= w_fresh_next;
            if (frame_start) begin
                r_disp_crouch <= (w_state_next == StCrouch);
                r_disp_right  <= facing_right;
            end
        end
    end

    always_comb begin
        w_pix = data_nL;
        unique case ({r_disp_crouch, r_disp_right})
            2'b00: w_pix = data_nL;
            2'b01: w_pix = data_nR;
            2'b10: w_pix = data_cL;
            2'b11: w_pix = data_cR;
            default: w_pix = data_nL;
        endcase
        w_on_next = r_inb2 && (w_pix != KEY_RGB);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pixel_rgb <= '0;
            r_doodle_on <= 1'b0;
        end else begin
            r_pixel_rgb <= w_on_next ? w_pix : 24'h000000;
            r_doodle_on <= w_on_next;
        end
    end

    assign read_address = r_read_address;
    assign pixel_rgb    = r_pixel_rgb;
    assign doodle_on    = r_doodle_on;

endmodule

// File: doc/doodle_sprite_fetch.md
# doodle_sprite_fetch

Per-pixel sprite fetch and compositing stage for the Doodle character. Consumes the VGA scan position and Doodle position, generates the shared 11-bit read address for the four 32×32 Doodle sprite RAMs (left/right × normal/crouch), and selects one of their registered 24-bit outputs. It runs a frame-counted crouch timer triggered by landing bounces and applies colour-key transparency. It emits an aligned `pixel_rgb`/`doodle_on` pair to the colour mapper.

## Interface
- `SPRITE_W`, 32: sprite edge in pixels; fixed at 32, so the address is {dy[4:0], dx[4:0]}.
- `CROUCH_FRAMES`, 8: frames the crouch sprite is shown after a bounce; must be ≥1.
- `KEY_RGB`, 24'hFFFFFF: transparent colour key.
- `Clk`  in  1  system/pixel clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `DrawX`, `DrawY`  in  10 each  current scan pixel.
- `frame_start`  in  1  one-cycle pulse at start of vertical blank.
- `DoodleX`, `DoodleY`  in  10 each  sprite top-left corner.
- `facing_right`  in  1  1 selects right-facing sprites.
- `bounce`  in  1  one-cycle pulse when the Doodle lands on a platform.
- `read_address`  out  11  shared read address to all four sprite RAMs.
- `data_nL`, `data_nR`, `data_cL`, `data_cR`  in  24 each  RAM outputs (normal/crouch, left/right).
- `pixel_rgb`  out  24  composited sprite colour.
- `doodle_on`  out  1  1 means `pixel_rgb` is opaque Doodle colour.

## Operation
- **Stage A (comb):**
  - dx = DrawX − DoodleX and dy = DrawY − DoodleY, computed as 11-bit two's complement.
  - in_box = (0 ≤ dx < 32) && (0 ≤ dy < 32).
  - addr = {1'b0, dy[4:0], dx[4:0]}.
- **Edge 1:**
  - read_address ← in_box ? addr : 0.
  - inb1 ← in_box.
- **Edge 2:**
  - Sprite RAMs register their data (RAM behaviour, external).
  - inb2 ← inb1.
- **Edge 3:**
  - sel = {disp_crouch, disp_right}.
  - pix = data selected by sel: 00→nL, 01→nR, 10→cL, 11→cR.
  - doodle_on ← inb2 && (pix ≠ KEY_RGB).
  - pixel_rgb ← doodle_on_next ? pix : 24'h000000.
- **Crouch FSM**, states NORMAL and CROUCH, counter `cnt` of width $clog2(CROUCH_FRAMES+1):
  - bounce (any state, with or without frame_start): state ← CROUCH, cnt ← CROUCH_FRAMES. Bounce has priority over decrement.
  - CROUCH && frame_start && !bounce:
    - cnt == 1: state ← NORMAL, cnt ← 0.
    - otherwise: cnt ← cnt − 1.
  - NORMAL without bounce: hold, cnt = 0.
- **Display select:**
  - Updated only on cycles with frame_start: disp_crouch ← (state_next == CROUCH), disp_right ← facing_right.
  - Held constant for the whole frame, so there is no mid-frame sprite tear.
- **Reset values (async, Reset_n = 0):**
  - read_address = 0, inb1 = inb2 = 0.
  - pixel_rgb = 0, doodle_on = 0.
  - state = NORMAL, cnt = 0.
  - disp_crouch = 0, disp_right = 1.

## Timing
- Latency is 3 cycles: the DrawX/DrawY sampled at edge 1 yields pixel_rgb/doodle_on valid after edge 3. Fully pipelined, one pixel per clock, no stalls.
- read_address is registered and glitch-free. It changes only on Clk edges.
- Sprite select changes take effect on the first pixel of the next frame: the first pixel whose edge-3 occurs after the frame_start cycle.
- A bounce pulse arriving mid-frame is not visible until the next frame_start.
- With CROUCH_FRAMES = N, crouch is shown for exactly N frames:
  - Bounce then frame_start: N frames.
  - Bounce coincident with frame_start: disp_crouch = 1 from that frame, N frames total.
- Boundary conditions:
  - Sprite partially off-screen: negative or ≥32 dx/dy gives doodle_on = 0. Wrapped 10-bit values must not alias into the box, because the compare is 11-bit signed.
  - Reset asserted mid-crouch or mid-line clears all state immediately. The first valid output comes 3 edges after release.

## Test plan
- **Reset:**
  - Stimulus: hold Reset_n = 0, then release.
  - Required: read_address = 0, pixel_rgb = 0, doodle_on = 0, disp_right = 1. No doodle_on until 3 edges after any in-box pixel.
- **Address/latency:**
  - Stimulus: DoodleX = 100, DoodleY = 200, DrawX = 105, DrawY = 203; RAM model returns 24'h123456.
  - Required: read_address = 11'd101 after edge 1; pixel_rgb = 24'h123456 with doodle_on = 1 after edge 3.
- **Transparency and edges:**
  - Stimulus: return KEY_RGB at an in-box pixel; separately drive DrawX = DoodleX − 1 and DrawX = DoodleX + 32.
  - Required: doodle_on = 0 and pixel_rgb = 0 in all three cases.
- **Crouch timer (CROUCH_FRAMES = 8):**
  - Stimulus: bounce, then 9 frame_start pulses, with facing_right = 1.
  - Required: data_cR is selected for frames 1–8 and data_nR from frame 9.
- **Bounce during crouch, coincident events:**
  - Stimulus: at cnt = 3, assert bounce and frame_start in the same cycle.
  - Required: cnt = 8, state = CROUCH, and 8 further crouch frames.
- **Reset mid-crouch:**
  - Stimulus: assert Reset_n = 0 asynchronously between edges while in CROUCH with cnt = 5.
  - Required: state = NORMAL, cnt = 0, disp_crouch = 0 before the next edge. The next frame uses the normal sprite.
